// File: rtl/quad_gen_pkg.sv
// rtl/quad_gen_pkg.sv - shared states, phase lookup and direction codes for the quadrature generator
package quad_gen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EDGE,
    DONE
  } state_t;

  // {a,b} for phases 3..0, packed high to low: 01, 11, 10, 00
  localparam logic [7:0] PHASE_AB_LUT = {2'b01, 2'b11, 2'b10, 2'b00};

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic logic [1:0] phase_ab(input logic [1:0] phase);
    return PHASE_AB_LUT[{phase, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/quad_tick_div.sv
// rtl/quad_tick_div.sv - loadable down-counter giving a one-cycle tick every load_val cycles
module quad_tick_div #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [DIV_W-1:0] load_val,
  output logic             tick
);

  localparam logic [DIV_W-1:0] CNT_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      reload <= '0;
    end else if (restart) begin
      cnt    <= load_val;
      reload <= load_val;
    end else if (cnt == CNT_ONE) begin
      cnt <= reload;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  assign tick = (cnt == CNT_ONE);

endmodule

// File: rtl/quad_enc_gen.sv
// rtl/quad_enc_gen.sv - quadrature A/B generator driven by signed step commands; QUAD_GEN_BOUNCE_EN adds contact bounce
module quad_enc_gen
  import quad_gen_pkg::*;
#(
  parameter int CNT_W = 8,
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0] cmd_div,
  input  logic             abort,
  output logic             enc_a,
  output logic             enc_b,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pos
);

  localparam int EDGE_W = CNT_W + 3;
  localparam logic [EDGE_W-1:0] EDGE_ONE = {{(EDGE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  POS_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [1:0]        phase, phase_nxt;
  logic              dir;
  logic [EDGE_W-1:0] edges_left;
  logic              ready_en;
  logic              tick;
  logic              accept;
  logic              do_edge;
  logic [DIV_W-1:0]  div_eff;
  logic [CNT_W:0]    steps_ext;
  logic [CNT_W:0]    steps_mag;
  logic [EDGE_W-1:0] edges_cmd;

  assign div_eff   = (cmd_div == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : cmd_div;
  // One extra bit so the most negative command still has a representable magnitude
  assign steps_ext = {cmd_steps[CNT_W-1], cmd_steps};
  assign steps_mag = cmd_steps[CNT_W-1] ? -steps_ext : steps_ext;
  assign edges_cmd = {steps_mag, 2'b00};

  assign cmd_ready = (state == IDLE) && !done && ready_en;
  assign busy      = (state != IDLE) || done;
  assign accept    = cmd_valid && cmd_ready;
  assign phase_nxt = (dir == DIR_UP) ? phase + 2'd1 : phase - 2'd1;

  quad_tick_div #(.DIV_W(DIV_W)) u_tick_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (accept),
    .load_val (div_eff),
    .tick     (tick)
  );

  always_comb begin
    state_nxt = state;
    do_edge   = 1'b0;
    case (state)
      IDLE: if (accept) state_nxt = (cmd_steps == '0) ? DONE : WAIT;
      WAIT: begin
        if (abort)     state_nxt = DONE;
        else if (tick) state_nxt = EDGE;
      end
      EDGE: begin
        // The edge is already committed here, so abort only cuts what follows it
        do_edge = 1'b1;
        if (abort || edges_left == EDGE_ONE) state_nxt = DONE;
        else if (tick)                       state_nxt = EDGE;
        else                                 state_nxt = WAIT;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= 2'd0;
      pos        <= '0;
      dir        <= DIR_UP;
      edges_left <= '0;
      done       <= 1'b0;
      ready_en   <= 1'b0;
    end else begin
      state    <= state_nxt;
      done     <= (state == DONE);
      ready_en <= 1'b1;
      if (accept) begin
        dir        <= cmd_steps[CNT_W-1] ? DIR_DOWN : DIR_UP;
        edges_left <= edges_cmd;
      end
      if (do_edge) begin
        phase      <= phase_nxt;
        edges_left <= edges_left - EDGE_ONE;
        if (phase_nxt == 2'd0) pos <= (dir == DIR_UP) ? pos + POS_ONE : pos - POS_ONE;
      end
    end
  end

`ifdef QUAD_GEN_BOUNCE_EN
  logic       bounce_ok;
  logic [1:0] bounce_stage;
  logic [1:0] ab_old;

  // Stage 1 replays the pre-edge levels for one cycle, stage 2 settles on the new phase
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_a        <= 1'b0;
      enc_b        <= 1'b0;
      bounce_ok    <= 1'b0;
      bounce_stage <= 2'd0;
      ab_old       <= 2'b00;
    end else begin
      if (accept) bounce_ok <= |div_eff[DIV_W-1:2];
      if (do_edge) begin
        {enc_a, enc_b} <= phase_ab(phase_nxt);
        ab_old         <= phase_ab(phase);
        bounce_stage   <= bounce_ok ? 2'd1 : 2'd0;
      end else if (bounce_stage == 2'd1) begin
        {enc_a, enc_b} <= ab_old;
        bounce_stage   <= 2'd2;
      end else if (bounce_stage == 2'd2) begin
        {enc_a, enc_b} <= phase_ab(phase);
        bounce_stage   <= 2'd0;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_a <= 1'b0;
      enc_b <= 1'b0;
    end else if (do_edge) begin
      {enc_a, enc_b} <= phase_ab(phase_nxt);
    end
  end
`endif

endmodule

// File: tb/tb_quad_enc_gen.sv
// tb/tb_quad_enc_gen.sv - randomized command bench for quad_enc_gen against a cycle-timed reference model
module tb_quad_enc_gen;

  localparam int CNT_W    = 8;
  localparam int DIV_W    = 16;
  localparam int POS_MASK = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_steps;
  logic [DIV_W-1:0] cmd_div;
  logic             abort;
  logic             enc_a;
  logic             enc_b;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pos;

  int n_cmp = 0;
  int n_bad = 0;
  int m_phase = 0;
  int m_pos = 0;
  // {a,b} as integers for phases 0..3: 00, 10, 11, 01
  int ab_lut [4] = '{0, 2, 3, 1};

  quad_enc_gen #(.CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_steps (cmd_steps),
    .cmd_div   (cmd_div),
    .abort     (abort),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .busy      (busy),
    .done      (done),
    .pos       (pos)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  function automatic int mod4(input int x);
    return ((x % 4) + 4) % 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // abort_rel: cycle (relative to accept) whose rising edge samples abort; -1 = never
  task automatic run_cmd(input int steps, input int div, input int abort_rel, input bit glitch);
    int deff, nedge, dir, last_e, done_rel, cut, n, ph, ps, ab, waited, e;
    deff   = (div == 0) ? 1 : div;
    nedge  = 4 * ((steps < 0) ? -steps : steps);
    dir    = (steps < 0) ? -1 : 1;
    last_e = (nedge == 0) ? 0 : deff + 1 + (nedge - 1) * deff;
    cut    = 1 << 30;
    done_rel = last_e + 1;
    if (nedge == 0) done_rel = 1;
    else if (abort_rel >= 1 && abort_rel <= last_e) begin
      cut      = abort_rel;
      done_rel = abort_rel + 1;
    end
    n = 0; ph = m_phase; ps = m_pos;
    waited = 0;
    @(negedge clk);
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_steps = steps[CNT_W-1:0];
    cmd_div   = div[DIV_W-1:0];
    abort     = (abort_rel == 0);
    @(posedge clk);
    for (int rel = 0; rel <= done_rel + 1; rel++) begin
      @(negedge clk);
      n = 0;
      for (int k = 0; k < nedge; k++) begin
        e = deff + 1 + k * deff;
        if (e <= rel && e <= cut) n++;
      end
      ph = mod4(m_phase + dir * n);
      ps = m_pos;
      for (int j = 1; j <= n; j++) if (mod4(m_phase + dir * j) == 0) ps += dir;
      ab = ab_lut[ph];
`ifdef QUAD_GEN_BOUNCE_EN
      if (deff >= 4 && n > 0 && deff + 1 + (n - 1) * deff == rel - 1)
        ab = ab_lut[mod4(m_phase + dir * (n - 1))];
`endif
      check("enc_ab", {enc_a, enc_b}, ab);
      check("pos", pos, ps & POS_MASK);
      check("busy", busy, rel <= done_rel);
      check("done", done, rel == done_rel);
      check("cmd_ready", cmd_ready, rel > done_rel);
      cmd_valid = glitch && (rel == 0);
      cmd_steps = 8'd5;
      abort     = (rel + 1 == abort_rel);
      @(posedge clk);
    end
    cmd_valid = 1'b0;
    abort     = 1'b0;
    m_phase   = ph;
    m_pos     = ps & POS_MASK;
  endtask

  initial begin
    int st, dv, ar, ne, le;
    rst_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_steps = '0; cmd_div = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_enc_ab", {enc_a, enc_b}, 0);
    check("rst_pos", pos, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_reset", cmd_ready, 1);

    run_cmd(1, 2, -1, 1'b0);
    run_cmd(-2, 1, -1, 1'b1);
    run_cmd(0, 3, -1, 1'b1);
    run_cmd(3, 4, 22, 1'b0);
    run_cmd(2, 0, -1, 1'b1);
    run_cmd(1, 1, 0, 1'b0);
    run_cmd(-128, 1, -1, 1'b0);
    run_cmd(1, 8, -1, 1'b0);

    @(negedge clk);
    cmd_valid = 1'b1; cmd_steps = 8'd3; cmd_div = 16'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_enc_ab", {enc_a, enc_b}, 0);
    check("midrst_pos", pos, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_after", cmd_ready, 1);
    m_phase = 0;
    m_pos   = 0;

    for (int i = 0; i < 40; i++) begin
      st = int'($urandom_range(12)) - 6;
      dv = int'($urandom_range(5));
      ne = 4 * ((st < 0) ? -st : st);
      le = (ne == 0) ? 0 : ((dv == 0) ? 1 : dv) * ne + 1;
      ar = ($urandom_range(2) == 0) ? int'($urandom_range(le + 2)) : -1;
      run_cmd(st, dv, ar, 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
